// File: rtl/dt_integrator_if.sv
// dt_integrator_if
//   Bundles the control, rate-sample and configuration inputs of the
//   dT integrator together with its temperature and status outputs.
//   master : the side that drives init/T_init/dT_in/dt_valid/k_dt/t_min/t_max
//   slave  : the integrator, which drives T_out/t_valid/t_upd/sat_hi/sat_lo/
//            stale/cfg_err
interface dt_integrator_if;
    logic       init;
    logic [7:0] T_init;
    logic [7:0] dT_in;
    logic       dt_valid;
    logic [7:0] k_dt;
    logic [7:0] t_min;
    logic [7:0] t_max;
    logic [7:0] T_out;
    logic       t_valid;
    logic       t_upd;
    logic       sat_hi;
    logic       sat_lo;
    logic       stale;
    logic       cfg_err;

    modport master (
        output init, T_init, dT_in, dt_valid, k_dt, t_min, t_max,
        input  T_out, t_valid, t_upd, sat_hi, sat_lo, stale, cfg_err
    );

    modport slave (
        input  init, T_init, dT_in, dt_valid, k_dt, t_min, t_max,
        output T_out, t_valid, t_upd, sat_hi, sat_lo, stale, cfg_err
    );
endinterface

// File: rtl/dt_integrator.sv
// dt_integrator
//   Reconstructs a temperature trajectory from Q7.0 rate samples. Each
//   accepted sample is scaled by 2^-k (k capped at 7) and added to a Q8.8
//   accumulator, which is clamped to [t_min, t_max] and presented as Q7.0.
//   A watchdog moves the block to STALE after TIMEOUT quiet RUN cycles.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : dt_integrator_if.slave
//            in : init, T_init, dT_in, dt_valid, k_dt, t_min, t_max
//            out: T_out (acc integer part, floor), t_valid (RUN),
//                 t_upd (one-cycle load/update pulse), sat_hi, sat_lo,
//                 stale (STALE), cfg_err (t_min > t_max, combinational)
module dt_integrator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    dt_integrator_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, STALE} state_t;

    state_t             state, state_nxt;
    logic [15:0]        idle_cnt, idle_cnt_nxt;
    logic signed [15:0] acc, acc_nxt;
    logic               t_upd_q, t_upd_nxt;
    logic               sat_hi_q, sat_hi_nxt;
    logic               sat_lo_q, sat_lo_nxt;

    logic               cfg_err;
    logic [2:0]         k_eff;
    logic signed [15:0] inc;
    logic signed [16:0] sum, cand, lo, hi;
    logic               load, update;

    // Datapath: 17-bit working width so acc+inc and the clamp compare
    // never overflow.
    always_comb begin
        cfg_err = $signed(bus.t_min) > $signed(bus.t_max);
        k_eff   = (bus.k_dt > 8'd7) ? 3'd7 : bus.k_dt[2:0];
        inc     = $signed({bus.dT_in, 8'h00}) >>> k_eff;
        sum     = {acc[15], acc} + {inc[15], inc};
        lo      = {bus.t_min[7], bus.t_min, 8'h00};
        hi      = {bus.t_max[7], bus.t_max, 8'h00};
        // init wins over a simultaneous sample; samples are ignored in IDLE
        load    = bus.init;
        update  = bus.dt_valid && !bus.init && (state != IDLE);
        cand    = load ? {bus.T_init[7], bus.T_init, 8'h00} : sum;
    end

    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        acc_nxt      = acc;
        t_upd_nxt    = 1'b0;
        sat_hi_nxt   = sat_hi_q;
        sat_lo_nxt   = sat_lo_q;

        if (load || update) begin
            state_nxt    = RUN;
            idle_cnt_nxt = '0;
            // An inverted window freezes the accumulator but not the FSM.
            if (!cfg_err) begin
                t_upd_nxt = 1'b1;
                if (cand > hi) begin
                    acc_nxt    = hi[15:0];
                    sat_hi_nxt = 1'b1;
                    sat_lo_nxt = 1'b0;
                end else if (cand < lo) begin
                    acc_nxt    = lo[15:0];
                    sat_hi_nxt = 1'b0;
                    sat_lo_nxt = 1'b1;
                end else begin
                    acc_nxt    = cand[15:0];
                    sat_hi_nxt = 1'b0;
                    sat_lo_nxt = 1'b0;
                end
            end
        end else begin
            case (state)
                RUN: begin
                    idle_cnt_nxt = idle_cnt + 16'd1;
                    if (idle_cnt == 16'(TIMEOUT - 1)) begin
                        state_nxt = STALE;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idle_cnt <= '0;
            acc      <= '0;
            t_upd_q  <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
            acc      <= acc_nxt;
            t_upd_q  <= t_upd_nxt;
            sat_hi_q <= sat_hi_nxt;
            sat_lo_q <= sat_lo_nxt;
        end
    end

    assign bus.T_out   = acc[15:8];
    assign bus.t_valid = (state == RUN);
    assign bus.stale   = (state == STALE);
    assign bus.t_upd   = t_upd_q;
    assign bus.sat_hi  = sat_hi_q;
    assign bus.sat_lo  = sat_lo_q;
    assign bus.cfg_err = cfg_err;
endmodule

// File: tb/tb_dt_integrator.sv
module tb_dt_integrator;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dt_integrator_if bus();

    dt_integrator #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: temperature as an integer count of 1/256 units,
    // mode 0 = idle, 1 = running, 2 = stale; quiet = quiet edges while running.
    int m_mode, m_acc, m_quiet;
    bit m_upd, m_shi, m_slo;

    function automatic int floor_div(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic void model(input bit r, input bit in, input int ti, input int dt,
                                  input bit dv, input int k, input int lo, input int hi);
        int ke, cand;
        if (!r) begin
            m_mode = 0; m_acc = 0; m_quiet = 0; m_upd = 0; m_shi = 0; m_slo = 0;
            return;
        end
        m_upd = 0;
        ke = (k > 7) ? 7 : k;
        if (in || (dv && m_mode != 0)) begin
            cand = in ? ti * 256 : m_acc + floor_div(dt * 256, 1 << ke);
            m_mode = 1;
            m_quiet = 0;
            if (lo <= hi) begin
                m_upd = 1;
                if (cand > hi * 256) begin
                    m_acc = hi * 256; m_shi = 1; m_slo = 0;
                end else if (cand < lo * 256) begin
                    m_acc = lo * 256; m_shi = 0; m_slo = 1;
                end else begin
                    m_acc = cand; m_shi = 0; m_slo = 0;
                end
            end
        end else if (m_mode == 1) begin
            m_quiet++;
            if (m_quiet >= TO) m_mode = 2;
        end
    endfunction

    function automatic logic [12:0] exp_vec();
        return {8'(floor_div(m_acc, 256)), m_mode == 1, m_upd, m_shi, m_slo, m_mode == 2};
    endfunction

    function automatic logic [12:0] act_vec();
        return {bus.T_out, bus.t_valid, bus.t_upd, bus.sat_hi, bus.sat_lo, bus.stale};
    endfunction

    task automatic step(input bit r, input bit in, input int ti, input int dt,
                        input bit dv, input int k, input int lo, input int hi);
        rst_n        = r;
        bus.init     = in;
        bus.T_init   = 8'(ti);
        bus.dT_in    = 8'(dt);
        bus.dt_valid = dv;
        bus.k_dt     = 8'(k);
        bus.t_min    = 8'(lo);
        bus.t_max    = 8'(hi);
        @(posedge clk);
        model(r, in, ti, dt, dv, k, lo, hi);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0, -128, 127);
        step(0, 0, 0, 0, 0, 0, -128, 127);
        n_cmp++;
        if (act_vec() !== 13'd0) begin
            n_bad++; $display("FAIL reset_vals act=%h exp=%h", act_vec(), 13'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 5, 1, 0, -128, 127);
            n_cmp++;
            if (act_vec() !== 13'd0) begin
                n_bad++; $display("FAIL idle_ignore%0d act=%h exp=%h", i, act_vec(), 13'd0);
            end
        end
    endtask

    task automatic test_basic();
        step(1, 1, 20, 0, 0, 0, -128, 127);
        n_cmp++;
        if (bus.T_out !== 8'd20 || bus.t_upd !== 1'b1) begin
            n_bad++; $display("FAIL basic_init act=%0d/%b exp=20/1", $signed(bus.T_out), bus.t_upd);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 3, 1, 0, -128, 127);
            n_cmp++;
            if (bus.T_out !== 8'(23 + 3 * i) || act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL basic_upd%0d act=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        step(1, 1, 20, 9, 1, 0, -128, 127);
        n_cmp++;
        if (bus.T_out !== 8'd20 || act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL init_prio act=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_fraction();
        int exp_a[4] = '{10, 10, 10, 11};
        int exp_b[2] = '{-6, -6};
        step(1, 1, 10, 0, 0, 2, -128, 127);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 1, 2, -128, 127);
            n_cmp++;
            if (bus.T_out !== 8'(exp_a[i]) || act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL frac_pos%0d act=%0d exp=%0d", i, $signed(bus.T_out), exp_a[i]);
            end
        end
        step(1, 1, -5, 0, 0, 1, -128, 127);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, -1, 1, 1, -128, 127);
            n_cmp++;
            if (bus.T_out !== 8'(exp_b[i]) || act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL frac_neg%0d act=%0d exp=%0d", i, $signed(bus.T_out), exp_b[i]);
            end
        end
        // 127*256/128 = 254 per sample; two samples reach 508 -> 1
        step(1, 1, 0, 0, 0, 200, -128, 127);
        step(1, 0, 0, 127, 1, 200, -128, 127);
        step(1, 0, 0, 127, 1, 200, -128, 127);
        n_cmp++;
        if (bus.T_out !== 8'd1 || act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL k_cap act=%0d exp=1", $signed(bus.T_out));
        end
    endtask

    task automatic test_saturation();
        step(1, 1, 28, 0, 0, 0, -128, 30);
        step(1, 0, 0, 5, 1, 0, -128, 30);
        n_cmp++;
        if (bus.T_out !== 8'd30 || bus.sat_hi !== 1'b1 || act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL sat_hi act=%h exp=%h", act_vec(), exp_vec());
        end
        step(1, 0, 0, -1, 1, 0, -128, 30);
        n_cmp++;
        if (bus.T_out !== 8'd29 || bus.sat_hi !== 1'b0 || act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL sat_hi_clr act=%h exp=%h", act_vec(), exp_vec());
        end
        step(1, 1, -8, 0, 0, 0, -10, 127);
        step(1, 0, 0, -5, 1, 0, -10, 127);
        n_cmp++;
        if (bus.T_out !== 8'hF6 || bus.sat_lo !== 1'b1 || act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL sat_lo act=%h exp=%h", act_vec(), exp_vec());
        end
        step(1, 0, 0, 1, 1, 0, -10, 127);
        n_cmp++;
        if (bus.T_out !== 8'hF7 || bus.sat_lo !== 1'b0 || act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL sat_lo_clr act=%h exp=%h", act_vec(), exp_vec());
        end
        step(1, 1, 50, 0, 0, 0, -128, 30);
        n_cmp++;
        if (bus.T_out !== 8'd30 || bus.sat_hi !== 1'b1 || act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL sat_init act=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_watchdog();
        logic [7:0] t0;
        step(1, 1, 0, 0, 0, 0, -128, 127);
        step(1, 0, 0, 1, 1, 0, -128, 127);
        t0 = bus.T_out;
        for (int i = 1; i <= TO; i++) begin
            step(1, 0, 0, 0, 0, 0, -128, 127);
            if (i == TO - 1) begin
                n_cmp++;
                if (bus.t_valid !== 1'b1 || bus.stale !== 1'b0 || act_vec() !== exp_vec()) begin
                    n_bad++; $display("FAIL wd_pre act=%b/%b exp=1/0", bus.t_valid, bus.stale);
                end
            end
        end
        n_cmp++;
        if (bus.t_valid !== 1'b0 || bus.stale !== 1'b1 || act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL wd_stale act=%b/%b exp=0/1", bus.t_valid, bus.stale);
        end
        step(1, 0, 0, 2, 1, 0, -128, 127);
        n_cmp++;
        if (bus.T_out !== t0 + 8'd2 || bus.stale !== 1'b0 || bus.t_valid !== 1'b1
            || act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL wd_resume act=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_cfg_err();
        logic [7:0] t0;
        t0 = bus.T_out;
        step(1, 0, 0, 4, 1, 0, 40, 30);
        n_cmp++;
        if (bus.cfg_err !== 1'b1 || bus.T_out !== t0 || bus.t_upd !== 1'b0
            || act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL cfg_err act=%b/%h/%b exp=1/%h/0", bus.cfg_err, bus.T_out, bus.t_upd, t0);
        end
        step(1, 1, 5, 0, 0, 0, 40, 30);
        n_cmp++;
        if (bus.T_out !== t0 || bus.t_upd !== 1'b0 || act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL cfg_err_init act=%h exp=%h", act_vec(), exp_vec());
        end
        step(1, 0, 0, 4, 1, 0, -128, 127);
        step(0, 1, 9, 4, 1, 0, -128, 127);
        n_cmp++;
        if (act_vec() !== 13'd0) begin
            n_bad++; $display("FAIL reset_mid act=%h exp=%h", act_vec(), 13'd0);
        end
    endtask

    task automatic test_random();
        int lo, hi, tmp, k, p;
        bit r, in, dv;
        for (int i = 0; i < 600; i++) begin
            case ((i / 60) % 3)
                0: p = 50;
                1: p = 5;
                default: p = 0;
            endcase
            r  = ($urandom_range(0, 99) != 0);
            in = ($urandom_range(0, 29) == 0);
            dv = ($urandom_range(0, 99) < p);
            k  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 255)) : int'($urandom_range(0, 7));
            lo = int'($urandom_range(0, 255)) - 128;
            hi = int'($urandom_range(0, 255)) - 128;
            if (lo > hi && $urandom_range(0, 9) != 0) begin
                tmp = lo; lo = hi; hi = tmp;
            end
            step(r, in, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 dv, k, lo, hi);
            n_cmp++;
            if (act_vec() !== exp_vec() || bus.cfg_err !== (lo > hi)) begin
                n_bad++; $display("FAIL rand%0d act=%h/%b exp=%h/%b", i, act_vec(), bus.cfg_err,
                                  exp_vec(), lo > hi);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fraction();
        test_saturation();
        test_watchdog();
        test_cfg_err();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
